sr_latch_bank: RTL and testbench



---
 rtl/sr_latch_bank.sv | 152 +++++++++++++++
 tb/tb_sr_latch_bank.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: clocked bank of independent SR storage channels.
// Each channel passes its s/r requests through an optional flop synchroniser,
// then updates a stored bit with a fixed S=R=1 resolution rule. A per-channel
// "known" flag marks channels written since reset, and conflict events are
// recorded in sticky per-channel flags plus a saturating event counter.
//
// Handshake: none. s and r are level-sensitive requests sampled every cycle;
// conflict_clr is a single-cycle pulse acted on at the edge where it is high.

module sr_latch_bank #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int CONFLICT_MODE = 0,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] q_known,
    output logic [WIDTH-1:0] conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Reject parameter combinations the storage logic cannot represent.
    generate
        if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1 || SYNC_STAGES < 0 ||
            CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_param
            $error("sr_latch_bank: illegal parameter value");
        end
    endgenerate

    // Synchronised view of the requests seen by the storage stage.
    logic [WIDTH-1:0] ss;
    logic [WIDTH-1:0] rs;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign ss = s;
            assign rs = r;
        end else begin : g_sync
            logic [WIDTH-1:0] s_pipe [SYNC_STAGES];
            logic [WIDTH-1:0] r_pipe [SYNC_STAGES];

            // Shift requests through the synchroniser; reset flushes in-flight data.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        s_pipe[i] <= '0;
                        r_pipe[i] <= '0;
                    end
                end else begin
                    s_pipe[0] <= s;
                    r_pipe[0] <= r;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        s_pipe[i] <= s_pipe[i-1];
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign ss = s_pipe[SYNC_STAGES-1];
            assign rs = r_pipe[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] conflict_vec;
    logic             conflict_any;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] known_nxt;
    logic [WIDTH-1:0] sticky_nxt;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_nxt;

    assign conflict_vec = ss & rs;
    assign conflict_any = |conflict_vec;

    // Per-channel next state from the synchronised request pair.
    always_comb begin
        q_nxt     = q;
        known_nxt = q_known;
        for (int i = 0; i < WIDTH; i++) begin
            case ({ss[i], rs[i]})
                2'b10: begin
                    q_nxt[i]     = 1'b1;
                    known_nxt[i] = 1'b1;
                end
                2'b01: begin
                    q_nxt[i]     = 1'b0;
                    known_nxt[i] = 1'b1;
                end
                2'b11: begin
                    case (CONFLICT_MODE)
                        1: begin
                            q_nxt[i]     = 1'b1;
                            known_nxt[i] = 1'b1;
                        end
                        2: begin
                            q_nxt[i]     = 1'b0;
                            known_nxt[i] = 1'b1;
                        end
                        3: begin
                            q_nxt[i]     = ~q[i];
                            known_nxt[i] = 1'b1;
                        end
                        default: begin
                            q_nxt[i]     = q[i];
                            known_nxt[i] = q_known[i];
                        end
                    endcase
                end
                default: begin
                    q_nxt[i]     = q[i];
                    known_nxt[i] = q_known[i];
                end
            endcase
        end
    end

    // Conflict bookkeeping: a clear is applied first so a same-cycle event survives it.
    always_comb begin
        cnt_base   = conflict_clr ? '0 : conflict_cnt;
        cnt_nxt    = cnt_base;
        sticky_nxt = (conflict_clr ? '0 : conflict_sticky) | conflict_vec;
        if (conflict_any && (cnt_base != CNT_MAX)) begin
            cnt_nxt = cnt_base + 1'b1;
        end
    end

    // Storage stage and conflict status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            q               <= '0;
            q_known         <= '0;
            conflict_sticky <= '0;
            conflict_cnt    <= '0;
        end else begin
            q               <= q_nxt;
            q_known         <= known_nxt;
            conflict_sticky <= sticky_nxt;
            conflict_cnt    <= cnt_nxt;
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// tb_sr_latch_bank: directed bench for sr_latch_bank.
// Four instances (CONFLICT_MODE 0..3, SYNC_STAGES=2) and one SYNC_STAGES=0
// instance share the same stimulus. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped when the output is sampled.

module tb_sr_latch_bank;

    localparam int W  = 4;
    localparam int CW = 3;
    localparam int SW = 32;

    logic          clk;
    logic          reset;
    logic [W-1:0]  s;
    logic [W-1:0]  r;
    logic          conflict_clr;

    logic [W-1:0]  q_m      [4];
    logic [W-1:0]  qn_m     [4];
    logic [W-1:0]  qk_m     [4];
    logic [W-1:0]  cs_m     [4];
    logic [CW-1:0] cc_m     [4];

    logic [W-1:0]  q_ns;
    logic [W-1:0]  qn_ns;
    logic [W-1:0]  qk_ns;
    logic [W-1:0]  cs_ns;
    logic [CW-1:0] cc_ns;

    logic [SW-1:0] exp_q[$];
    string         tag_q[$];
    int            tests_run;
    int            tests_failed;

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            sr_latch_bank #(
                .WIDTH(W), .SYNC_STAGES(2), .CONFLICT_MODE(g), .CNT_W(CW)
            ) dut (
                .clk(clk), .reset(reset), .s(s), .r(r),
                .conflict_clr(conflict_clr),
                .q(q_m[g]), .q_n(qn_m[g]), .q_known(qk_m[g]),
                .conflict_sticky(cs_m[g]), .conflict_cnt(cc_m[g])
            );
        end
    endgenerate

    sr_latch_bank #(
        .WIDTH(W), .SYNC_STAGES(0), .CONFLICT_MODE(0), .CNT_W(CW)
    ) dut_ns (
        .clk(clk), .reset(reset), .s(s), .r(r),
        .conflict_clr(conflict_clr),
        .q(q_ns), .q_n(qn_ns), .q_known(qk_ns),
        .conflict_sticky(cs_ns), .conflict_cnt(cc_ns)
    );

    // Driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [W-1:0] s_v, input logic [W-1:0] r_v);
        s = s_v;
        r = r_v;
    endtask

    // Scoreboard
    task automatic push_exp(input string tag, input logic [SW-1:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [SW-1:0] obs);
        string         tag;
        logic [SW-1:0] exp_v;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL scoreboard_empty: got %0h expected <none>", obs);
        end else begin
            tag   = tag_q.pop_front();
            exp_v = exp_q.pop_front();
            tests_run++;
            assert (obs === exp_v) else begin
                tests_failed++;
                $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        conflict_clr = 1'b0;
        drive(4'hF, 4'h0);

        // Reset with s held high
        push_exp("rst_q", 0);
        push_exp("rst_q_n", 32'hF);
        push_exp("rst_known", 0);
        push_exp("rst_sticky", 0);
        push_exp("rst_cnt", 0);
        push_exp("rst_q_nosync", 0);
        tick(2);
        check(32'(q_m[0]));
        check(32'(qn_m[0]));
        check(32'(qk_m[0]));
        check(32'(cs_m[0]));
        check(32'(cc_m[0]));
        check(32'(q_ns));

        // Release reset, set ch0: 3-edge latency (1 edge with no synchroniser)
        reset = 1'b0;
        drive(4'b0001, 4'b0000);
        push_exp("nosync_lat1_q", 32'b0001);
        push_exp("lat_edge2_q", 0);
        push_exp("lat_edge3_q", 32'b0001);
        push_exp("lat_edge3_known", 32'b0001);
        tick(1);
        check(32'(q_ns));
        tick(1);
        check(32'(q_m[0]));
        tick(1);
        check(32'(q_m[0]));
        check(32'(qk_m[0]));

        // Latch ch1 with a one-cycle set, then hold for 10 cycles
        drive(4'b0010, 4'b0000);
        push_exp("set_ch1_q", 32'b0011);
        tick(1);
        drive(4'b0000, 4'b0000);
        tick(2);
        check(32'(q_m[0]));
        push_exp("hold_ch1_q", 32'b0011);
        tick(10);
        check(32'(q_m[0]));

        // Reset ch1, then confirm q_n during hold
        drive(4'b0000, 4'b0010);
        push_exp("rst_ch1_q", 32'b0001);
        push_exp("hold_q_n", 32'b1110);
        push_exp("hold_known", 32'b0011);
        tick(1);
        drive(4'b0000, 4'b0000);
        tick(2);
        check(32'(q_m[0]));
        tick(3);
        check(32'(qn_m[0]));
        check(32'(qk_m[0]));

        // Hold conflict on ch0 for 10 cycles: counter saturates at 7
        drive(4'b0001, 4'b0001);
        push_exp("sat_cnt", 32'd7);
        push_exp("sat_sticky", 32'b0001);
        push_exp("sat_hold_q", 32'b0001);
        tick(10);
        check(32'(cc_m[0]));
        check(32'(cs_m[0]));
        check(32'(q_m[0]));
        drive(4'b0000, 4'b0000);
        push_exp("sat_stays_cnt", 32'd7);
        tick(3);
        check(32'(cc_m[0]));

        // Clear with no conflict present
        conflict_clr = 1'b1;
        push_exp("clr_cnt", 0);
        push_exp("clr_sticky", 0);
        tick(1);
        conflict_clr = 1'b0;
        check(32'(cc_m[0]));
        check(32'(cs_m[0]));

        // Clear on the third of three conflict edges: the new event wins
        drive(4'b0001, 4'b0001);
        push_exp("clr_conf_cnt", 32'd1);
        push_exp("clr_conf_sticky", 32'b0001);
        push_exp("clr_conf_cnt_after", 32'd1);
        tick(3);
        drive(4'b0000, 4'b0000);
        tick(1);
        conflict_clr = 1'b1;
        tick(1);
        conflict_clr = 1'b0;
        check(32'(cc_m[0]));
        check(32'(cs_m[0]));
        tick(2);
        check(32'(cc_m[0]));

        // Conflict modes: start from q[2]=1, hold s[2]=r[2]=1 for 2 cycles
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        drive(4'b0100, 4'b0000);
        push_exp("mode_pre_q", 32'b0100);
        tick(1);
        drive(4'b0000, 4'b0000);
        tick(2);
        check(32'(q_m[3]));
        drive(4'b0100, 4'b0100);
        push_exp("mode0_e1_q", 32'b0100);
        push_exp("mode1_e1_q", 32'b0100);
        push_exp("mode2_e1_q", 32'b0000);
        push_exp("mode3_e1_q", 32'b0000);
        push_exp("mode0_e2_q", 32'b0100);
        push_exp("mode1_e2_q", 32'b0100);
        push_exp("mode2_e2_q", 32'b0000);
        push_exp("mode3_e2_q", 32'b0100);
        push_exp("mode0_known", 32'b0100);
        push_exp("mode3_q_n", 32'b1011);
        tick(2);
        drive(4'b0000, 4'b0000);
        tick(1);
        for (int m = 0; m < 4; m++) check(32'(q_m[m]));
        tick(1);
        for (int m = 0; m < 4; m++) check(32'(q_m[m]));
        check(32'(qk_m[0]));
        check(32'(qn_m[3]));

        // Mid-operation reset with r[3] in flight
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        drive(4'b1000, 4'b0000);
        push_exp("mid_set_q", 32'b1000);
        push_exp("mid_set_known", 32'b1000);
        tick(1);
        drive(4'b0000, 4'b0000);
        tick(2);
        check(32'(q_m[0]));
        check(32'(qk_m[0]));
        drive(4'b0000, 4'b1000);
        tick(1);
        reset = 1'b1;
        push_exp("mid_rst_q", 0);
        push_exp("mid_rst_known", 0);
        push_exp("mid_pending_known", 0);
        push_exp("mid_post_known", 32'b1000);
        push_exp("mid_post_q", 0);
        tick(1);
        reset = 1'b0;
        check(32'(q_m[0]));
        check(32'(qk_m[0]));
        tick(2);
        check(32'(qk_m[0]));
        tick(1);
        check(32'(qk_m[0]));
        check(32'(q_m[0]));
        drive(4'b0000, 4'b0000);

        // Every pushed expectation must have been consumed
        tests_run++;
        assert (exp_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
